// File: rtl/apb_master_bridge_if.sv
// Command/response and APB bus bundle for apb_master_bridge.
// master = bridge side, slave = command source / APB completer side.
interface apb_master_bridge_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_SLAVES    = 4
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                           req_valid;
    logic                           req_ready;
    logic                           req_write;
    logic [ADDRESS_WIDTH-1:0]       req_addr;
    logic [DATA_WIDTH-1:0]          req_wdata;
    logic [STRB_WIDTH-1:0]          req_strb;

    logic                           rsp_valid;
    logic [DATA_WIDTH-1:0]          rsp_rdata;
    logic [1:0]                     rsp_code;

    logic [NUM_SLAVES-1:0]          PSEL;
    logic                           PENABLE;
    logic                           PWRITE;
    logic [ADDRESS_WIDTH-1:0]       PADDR;
    logic [DATA_WIDTH-1:0]          PWDATA;
    logic [STRB_WIDTH-1:0]          PSTRB;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]          PREADY;
    logic [NUM_SLAVES-1:0]          PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_code,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_code,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB master bridge: one command at a time through IDLE->SETUP->ACCESS->RESP, all outputs registered.
// Accept->rsp_valid is 3 cycles plus wait states (1 on decode error); req_ready stays low while busy.
module apb_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    apb_master_bridge_if.master bus
);
    localparam int SEL_BITS = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] CODE_OK      = 2'b00;
    localparam logic [1:0] CODE_SLVERR  = 2'b01;
    localparam logic [1:0] CODE_DECERR  = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                 state, state_nxt;
    logic [SEL_BITS-1:0]    idx, idx_nxt, req_idx;
    logic [CNT_W-1:0]       wait_cnt, wait_cnt_nxt, wait_inc;
    logic                   idx_ok;
    logic                   sel_ready, sel_err;
    logic [DATA_WIDTH-1:0]  sel_rdata;

    logic                   req_ready_nxt, rsp_valid_nxt, penable_nxt, pwrite_nxt;
    logic [1:0]             rsp_code_nxt;
    logic [DATA_WIDTH-1:0]  rsp_rdata_nxt, pwdata_nxt;
    logic [NUM_SLAVES-1:0]  psel_nxt;
    logic [ADDRESS_WIDTH-1:0] paddr_nxt;
    logic [STRB_W-1:0]      pstrb_nxt;

    assign req_idx = bus.req_addr[ADDRESS_WIDTH-1 -: SEL_BITS];
    assign idx_ok  = (int'(req_idx) < NUM_SLAVES);

    // Only the latched target's PREADY/PSLVERR/PRDATA are ever looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx == SEL_BITS'(i)) begin
                sel_ready = bus.PREADY[i];
                sel_err   = bus.PSLVERR[i];
                sel_rdata = bus.PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        wait_inc      = wait_cnt + 1'b1;
        wait_cnt_nxt  = wait_cnt;
        req_ready_nxt = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_code_nxt  = CODE_OK;
        rsp_rdata_nxt = '0;
        psel_nxt      = bus.PSEL;
        penable_nxt   = bus.PENABLE;
        pwrite_nxt    = bus.PWRITE;
        paddr_nxt     = bus.PADDR;
        pwdata_nxt    = bus.PWDATA;
        pstrb_nxt     = bus.PSTRB;

        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (idx_ok) begin
                        state_nxt  = SETUP;
                        idx_nxt    = req_idx;
                        psel_nxt   = NUM_SLAVES'(1) << req_idx;
                        paddr_nxt  = bus.req_addr;
                        pwrite_nxt = bus.req_write;
                        pwdata_nxt = bus.req_write ? bus.req_wdata : '0;
                        pstrb_nxt  = bus.req_write ? bus.req_strb  : '0;
                    end else begin
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_code_nxt  = CODE_DECERR;
                    end
                end
            end
            SETUP: begin
                state_nxt    = ACCESS;
                penable_nxt  = 1'b1;
                wait_cnt_nxt = '0;
            end
            ACCESS: begin
                if (sel_ready) begin
                    state_nxt     = RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_code_nxt  = sel_err ? CODE_SLVERR : CODE_OK;
                    rsp_rdata_nxt = bus.PWRITE ? '0 : sel_rdata;
                end else begin
                    wait_cnt_nxt = wait_inc;
                    if (wait_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_code_nxt  = CODE_TIMEOUT;
                    end
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        req_ready_nxt = (state_nxt == IDLE);
        // APB side is quiet whenever no transfer is in flight.
        if (state_nxt == IDLE || state_nxt == RESP) begin
            psel_nxt    = '0;
            penable_nxt = 1'b0;
            pwrite_nxt  = 1'b0;
            paddr_nxt   = '0;
            pwdata_nxt  = '0;
            pstrb_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            wait_cnt      <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_code  <= 2'b00;
            bus.rsp_rdata <= '0;
            bus.PSEL      <= '0;
            bus.PENABLE   <= 1'b0;
            bus.PWRITE    <= 1'b0;
            bus.PADDR     <= '0;
            bus.PWDATA    <= '0;
            bus.PSTRB     <= '0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            wait_cnt      <= wait_cnt_nxt;
            bus.req_ready <= req_ready_nxt;
            bus.rsp_valid <= rsp_valid_nxt;
            bus.rsp_code  <= rsp_code_nxt;
            bus.rsp_rdata <= rsp_rdata_nxt;
            bus.PSEL      <= psel_nxt;
            bus.PENABLE   <= penable_nxt;
            bus.PWRITE    <= pwrite_nxt;
            bus.PADDR     <= paddr_nxt;
            bus.PWDATA    <= pwdata_nxt;
            bus.PSTRB     <= pstrb_nxt;
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: per-cycle expected trace built from the transfer rules,
// driven by directed cases and randomized commands with random completer wait states.
module tb_apb_master_bridge;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int NS   = 3;
    localparam int TO   = 16;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_master_bridge_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_SLAVES(NS)) bus ();

    apb_master_bridge #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic          req_ready;
        logic          rsp_valid;
        logic [1:0]    rsp_code;
        logic [DW-1:0] rsp_rdata;
        logic [NS-1:0] psel;
        logic          penable;
        logic          pwrite;
        logic [AW-1:0] paddr;
        logic [DW-1:0] pwdata;
        logic [3:0]    pstrb;
    } exp_t;

    exp_t exp_tr [MAXC];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    // monitor totals, written only by the compare process
    int          psel_cnt = 0, pen_cnt = 0, rsp_cnt = 0, last_rsp_cyc = 0;
    logic [1:0]  last_code = 2'b00;
    logic [31:0] last_rdata = '0, last_paddr = '0;
    logic [NS-1:0] last_psel = '0;

    // completer behaviour for the current command
    int          cur_w = 0;
    bit          cur_err = 1'b0;
    logic [31:0] cur_rd = '0;
    int          acc_cnt [NS];
    int          acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t idle_exp();
        exp_t e;
        e = '0;
        e.req_ready = 1'b1;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (cyc < MAXC) begin
            chk("req_ready", 64'(bus.req_ready), 64'(exp_tr[cyc].req_ready));
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_tr[cyc].rsp_valid));
            chk("rsp_code",  64'(bus.rsp_code),  64'(exp_tr[cyc].rsp_code));
            chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_tr[cyc].rsp_rdata));
            chk("psel",      64'(bus.PSEL),      64'(exp_tr[cyc].psel));
            chk("penable",   64'(bus.PENABLE),   64'(exp_tr[cyc].penable));
            chk("pwrite",    64'(bus.PWRITE),    64'(exp_tr[cyc].pwrite));
            chk("paddr",     64'(bus.PADDR),     64'(exp_tr[cyc].paddr));
            chk("pwdata",    64'(bus.PWDATA),    64'(exp_tr[cyc].pwdata));
            chk("pstrb",     64'(bus.PSTRB),     64'(exp_tr[cyc].pstrb));
        end
        if (bus.PSEL != '0) begin
            psel_cnt++;
            last_psel  = bus.PSEL;
            last_paddr = bus.PADDR;
        end
        if (bus.PENABLE) pen_cnt++;
        if (bus.rsp_valid) begin
            rsp_cnt++;
            last_rsp_cyc = cyc;
            last_code    = bus.rsp_code;
            last_rdata   = bus.rsp_rdata;
        end
    end

    // Completer: selected slave raises PREADY on ACCESS cycle cur_w+1; everything else is noise.
    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (bus.PSEL[i] && bus.PENABLE) acc_cnt[i] = acc_cnt[i] + 1;
            else                            acc_cnt[i] = 0;
            if (acc_cnt[i] > cur_w) begin
                bus.PREADY[i]          = 1'b1;
                bus.PSLVERR[i]         = cur_err;
                bus.PRDATA[i*DW +: DW] = cur_rd;
            end else if (acc_cnt[i] > 0) begin
                bus.PREADY[i]          = 1'b0;
                bus.PSLVERR[i]         = 1'($urandom);
                bus.PRDATA[i*DW +: DW] = $urandom;
            end else begin
                bus.PREADY[i]          = 1'($urandom);
                bus.PSLVERR[i]         = 1'($urandom);
                bus.PRDATA[i*DW +: DW] = $urandom;
            end
        end
    end

    task automatic drive_junk(input bit v);
        bus.req_valid = v;
        bus.req_write = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_strb  = 4'($urandom);
    endtask

    // Issue one command, extend the expected trace, optionally reset at offset rst_at (-1 = random).
    task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int w, input bit err,
                          input logic [31:0] rd, input int gap, input int rst_at);
        int c, len, n, idx, k_rst;
        logic [1:0] code;
        exp_t e;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            drive_junk(1'b0);
        end
        @(negedge clk);
        cur_w = w; cur_err = err; cur_rd = rd;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
        bus.req_wdata = wdata; bus.req_strb = strb;
        c = cyc;
        acc_cyc = c;
        idx = int'(addr[31:30]);
        e = idle_exp();
        e.req_ready = 1'b0;
        if (idx >= NS) begin
            len = 1;
            e.rsp_valid = 1'b1;
            e.rsp_code  = 2'd2;
            exp_tr[c+1] = e;
        end else begin
            n    = (w >= TO) ? TO : w + 1;
            code = (w >= TO) ? 2'd3 : (err ? 2'd1 : 2'd0);
            len  = n + 2;
            e.psel   = NS'(1 << idx);
            e.paddr  = addr;
            e.pwrite = wr;
            e.pwdata = wr ? wdata : 32'd0;
            e.pstrb  = wr ? strb : 4'd0;
            exp_tr[c+1] = e;
            e.penable = 1'b1;
            for (int k = 2; k <= n + 1; k++) exp_tr[c+k] = e;
            e = idle_exp();
            e.req_ready = 1'b0;
            e.rsp_valid = 1'b1;
            e.rsp_code  = code;
            e.rsp_rdata = (!wr && code < 2'd2) ? rd : 32'd0;
            exp_tr[c+len] = e;
        end
        k_rst = rst_at;
        if (rst_at < 0) k_rst = (len >= 3) ? int'($urandom_range(1, len - 1)) : 0;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == k_rst) begin
                rst = 1'b1;
                drive_junk(1'b1);
                for (int j = k + 1; j <= len; j++) exp_tr[c+j] = idle_exp();
                @(negedge clk);
                rst = 1'b0;
                bus.req_valid = 1'b0;
                break;
            end
            drive_junk(1'b1);
        end
    endtask

    initial begin
        #(MAXC * 20);
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s_psel, s_pen, s_rsp;
        for (int i = 0; i < MAXC; i++) exp_tr[i] = idle_exp();
        rst = 1'b1;
        drive_junk(1'b1);
        repeat (3) begin
            @(negedge clk);
            drive_junk(1'b1);
        end
        rst = 1'b0;
        bus.req_valid = 1'b0;

        // zero-wait write to slave 2
        s_psel = psel_cnt; s_pen = pen_cnt;
        do_cmd(1'b1, 32'hABBA0000, 32'hABCDEF01, 4'hF, 0, 1'b0, 32'h0, 1, 0);
        chk("d1_latency", 64'(last_rsp_cyc - acc_cyc), 64'd3);
        chk("d1_code",    64'(last_code), 64'd0);
        chk("d1_psel_cyc", 64'(psel_cnt - s_psel), 64'd2);
        chk("d1_pen_cyc",  64'(pen_cnt - s_pen), 64'd1);
        chk("d1_psel_val", 64'(last_psel), 64'h4);

        // read with 3 wait states from slave 1
        s_pen = pen_cnt;
        do_cmd(1'b0, 32'h40000010, 32'h5555AAAA, 4'h9, 3, 1'b0, 32'hACFED000, 2, 0);
        chk("d2_pen_cyc", 64'(pen_cnt - s_pen), 64'd4);
        chk("d2_rdata",   64'(last_rdata), 64'hACFED000);
        chk("d2_code",    64'(last_code), 64'd0);
        chk("d2_paddr",   64'(last_paddr), 64'h40000010);
        chk("d2_latency", 64'(last_rsp_cyc - acc_cyc), 64'd6);

        // slave error on read
        do_cmd(1'b0, 32'h80000004, 32'h0, 4'h0, 0, 1'b1, 32'hAFFED0F0, 0, 0);
        chk("d3_code",  64'(last_code), 64'd1);
        chk("d3_rdata", 64'(last_rdata), 64'hAFFED0F0);

        // decode error: index 3
        s_psel = psel_cnt;
        do_cmd(1'b1, 32'hCAFE0000, 32'h11112222, 4'hF, 0, 1'b0, 32'h0, 1, 0);
        chk("d4_psel_cyc", 64'(psel_cnt - s_psel), 64'd0);
        chk("d4_latency",  64'(last_rsp_cyc - acc_cyc), 64'd1);
        chk("d4_code",     64'(last_code), 64'd2);

        // timeout on slave 0, then a normal command
        s_pen = pen_cnt;
        do_cmd(1'b0, 32'h00000000, 32'h0, 4'h0, 100, 1'b0, 32'h12345678, 1, 0);
        chk("d5_code",    64'(last_code), 64'd3);
        chk("d5_rdata",   64'(last_rdata), 64'd0);
        chk("d5_pen_cyc", 64'(pen_cnt - s_pen), 64'd16);
        chk("d5_latency", 64'(last_rsp_cyc - acc_cyc), 64'd18);
        do_cmd(1'b1, 32'h40000020, 32'hDEADBEEF, 4'h3, 0, 1'b0, 32'h0, 0, 0);
        chk("d5_next_code", 64'(last_code), 64'd0);
        chk("d5_next_lat",  64'(last_rsp_cyc - acc_cyc), 64'd3);

        // reset during 2nd ACCESS cycle of a wait-stated write
        s_rsp = rsp_cnt;
        do_cmd(1'b1, 32'h40000030, 32'hCAFEF00D, 4'hF, 5, 1'b0, 32'h0, 1, 3);
        chk("d6_psel",      64'(bus.PSEL), 64'd0);
        chk("d6_penable",   64'(bus.PENABLE), 64'd0);
        chk("d6_req_ready", 64'(bus.req_ready), 64'd1);
        chk("d6_no_rsp",    64'(rsp_cnt - s_rsp), 64'd0);
        do_cmd(1'b0, 32'h80000040, 32'h0, 4'h0, 1, 1'b0, 32'h0BADCAFE, 0, 0);
        chk("d6_next_rdata", 64'(last_rdata), 64'h0BADCAFE);

        // randomized commands
        for (int t = 0; t < 200; t++) begin
            logic [1:0]  ridx;
            logic [31:0] raddr;
            int          rw;
            if (cyc > MAXC - 64) break;
            ridx  = 2'($urandom_range(0, 3));
            raddr = {ridx, 30'($urandom)};
            rw    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(14, 18))
                                                : int'($urandom_range(0, 4));
            do_cmd(1'($urandom), raddr, $urandom, 4'($urandom), rw, 1'($urandom),
                   $urandom, int'($urandom_range(0, 2)),
                   ($urandom_range(0, 19) == 0) ? -1 : 0);
        end

        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameters SHALL be:
  DATA_WIDTH  32  PWDATA/PRDATA width, multiple of 8
  ADDRESS_WIDTH  32  PADDR width
  NUM_SLAVES  4  number of PSEL lines, 1..16
  TIMEOUT_CYCLES  16  maximum ACCESS cycles with PREADY low before abort
REQ-002 SEL_BITS SHALL be derived as clog2(NUM_SLAVES), minimum 1; slave index = req_addr[ADDRESS_WIDTH-1 -: SEL_BITS].
REQ-003 Ports (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  synchronous, active-high reset
  req_valid  in  1  command offered
  req_ready  out  1  bridge can accept a command
  req_write  in  1  1=write, 0=read
  req_addr  in  ADDRESS_WIDTH  target address
  req_wdata  in  DATA_WIDTH  write data
  req_strb  in  DATA_WIDTH/8  write byte strobes
  rsp_valid  out  1  one-cycle completion pulse
  rsp_rdata  out  DATA_WIDTH  read data
  rsp_code  out  2  00 OK, 01 SLVERR, 10 DECERR, 11 TIMEOUT
  PSEL  out  NUM_SLAVES  one-hot slave select
  PENABLE  out  1  APB access phase
  PWRITE  out  1  APB direction
  PADDR  out  ADDRESS_WIDTH  APB address
  PWDATA  out  DATA_WIDTH  APB write data
  PSTRB  out  DATA_WIDTH/8  APB write strobes
  PRDATA  in  NUM_SLAVES*DATA_WIDTH  per-slave read data; slave i at bits [i*DATA_WIDTH +: DATA_WIDTH]
  PREADY  in  NUM_SLAVES  per-slave ready
  PSLVERR  in  NUM_SLAVES  per-slave error

Function
REQ-004 The FSM SHALL have four states: IDLE, SETUP, ACCESS and RESP; all outputs SHALL be registered.
REQ-005 req_ready SHALL be 1 only in IDLE; a command is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-006 Accepting a command with a valid index (< NUM_SLAVES) SHALL move the FSM IDLE->SETUP and latch addr, write, wdata, strb and index.
REQ-007 SETUP SHALL last exactly one cycle with PSEL[index]=1 and PENABLE=0, then move to ACCESS.
REQ-008 ACCESS SHALL drive PSEL[index]=1 and PENABLE=1, and SHALL remain in ACCESS while PREADY[index]=0.
REQ-009 When PREADY[index]=1 is sampled in ACCESS, the FSM SHALL move to RESP, capture PRDATA slice and PSLVERR[index], and deassert PSEL and PENABLE.
REQ-010 RESP SHALL last one cycle: rsp_valid=1 with rsp_code, then the FSM SHALL return to IDLE. Zero-wait latency from accept edge to rsp_valid is 3 cycles.
REQ-011 PADDR, PWRITE, PWDATA and PSTRB SHALL be stable from SETUP through the last ACCESS cycle.
REQ-012 On reads, PWDATA and PSTRB SHALL be driven 0.
REQ-013 rsp_rdata SHALL equal the captured PRDATA for reads with code OK or SLVERR, and 0 in all other cases.
REQ-014 At most one PSEL bit SHALL be high in any cycle. PSEL, PENABLE and PADDR SHALL be 0 in IDLE and RESP.
REQ-015 A command with index >= NUM_SLAVES SHALL go IDLE->RESP directly, produce no PSEL activity, and return rsp_code 10.
REQ-016 The wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADY[index]=0.
REQ-017 When the wait counter reaches TIMEOUT_CYCLES, the FSM SHALL abort to RESP with rsp_code 11 and deassert PSEL and PENABLE.
REQ-018 PREADY and PSLVERR of unselected slaves SHALL be ignored; PSLVERR SHALL be sampled only together with PREADY=1.

Reset
REQ-019 While rst=1 at a clock edge: FSM=IDLE, wait counter=0, all outputs 0 except req_ready=1.
REQ-020 A reset asserted mid-transfer (SETUP, ACCESS or RESP) SHALL abort the transfer with no rsp_valid pulse, and PSEL SHALL be 0 in the cycle after that edge.

Verification (bench with NUM_SLAVES=3, TIMEOUT_CYCLES=16)
REQ-021 Write 0xABCDEF01 to 0xABBA0000, strb 0xF, slave 2 PREADY tied 1 -> PSEL=3'b100 for 2 cycles, PENABLE high 1 cycle, rsp_valid 3 cycles after accept, code 00.
REQ-022 Read 0x40000010, slave 1 holds PREADY low 3 ACCESS cycles then returns 0xACFED000 -> 4 ACCESS cycles, PADDR stable throughout, PSTRB=0, rsp_rdata=0xACFED000, code 00.
REQ-023 Read 0x80000004, slave 2 returns PREADY=1, PSLVERR=1, PRDATA=0xAFFED0F0 -> code 01, rsp_rdata=0xAFFED0F0.
REQ-024 Write to 0xCAFE0000 (index 3) -> PSEL stays 0, rsp_valid 1 cycle after accept, code 10.
REQ-025 Read 0x00000000, slave 0 PREADY held low -> abort after 16 wait cycles, code 11, rsp_rdata=0; next command accepted normally.
REQ-026 Assert rst during the 2nd ACCESS cycle of a wait-stated write -> PSEL and PENABLE are 0 the next cycle, no rsp_valid, req_ready=1.
